key_xor_stream: RTL

Byte-stream cipher stage directly downstream of the key register. Once key entry is closed (`kset` high), it snapshots the up-to-four 8-bit key bytes and their count. It then XORs each incoming data byte with the key bytes in rotating order, `keys[7:0]` first. Data moves over valid/ready handshakes on both sides through a single registered output stage, so this block is the data path between byte intake and the byte sink.

---
 rtl/yoda_pkg.sv | 25 ++
 rtl/key_index_ctr.sv | 46 ++++
 rtl/key_xor_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/yoda_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : yoda_pkg
//  Description : Shared types and constants for the key XOR stream cipher.
//  Revision    : 1.0 - initial release
// ============================================================================
package yoda_pkg;

  localparam int KEY_BYTE_W = 8;
  localparam int MAX_KEYS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // A key count is usable only when it selects 1..MAX_KEYS bytes
  function automatic logic num_keys_ok(input logic [2:0] n);
    return (n >= 3'd1) && (n <= 3'(MAX_KEYS));
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_index_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : key_index_ctr
//  Description : Modulo-n wrapping index counter with clear and advance.
//                Clear wins over advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_index_ctr #(
  parameter int IDX_W = 2,
  parameter int N_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [N_W-1:0]   n,
  output logic [IDX_W-1:0] idx
);

  localparam logic [N_W-1:0] C_ONE = N_W'(1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             last;

  // Next index: restart on clear, wrap to zero after the last valid key
  always_comb begin
    last  = ({{(N_W-IDX_W){1'b0}}, idx_q} == (n - C_ONE));
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d = last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx = idx_q;

endmodule
`default_nettype wire

// File: rtl/key_xor_stream.sv
`default_nettype none
// ============================================================================
//  Module      : key_xor_stream
//  Description : XORs a valid/ready byte stream with up to four snapshotted
//                key bytes in rotating order through one registered stage.
//                Define KEY_XOR_CHAIN_EN to add ciphertext chaining
//                (mode 0 = encrypt, 1 = decrypt); otherwise plain XOR.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_xor_stream
  import yoda_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              kset,
  input  logic [31:0]       keys,
  input  logic [2:0]        num_keys,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              key_err,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int C_IDX_W = $clog2(MAX_KEYS);

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                key_err_q, key_err_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]         key_snap_q, key_snap_d;
  logic [2:0]          n_snap_q, n_snap_d;
  logic [C_IDX_W-1:0]  idx;
  logic                idx_clr;
  logic                accept;
  logic [DATA_W-1:0]   key_byte;
  logic [DATA_W-1:0]   xor_val;
`ifdef KEY_XOR_CHAIN_EN
  logic [DATA_W-1:0]   chain_q, chain_d;
`else
  logic                unused_mode;
  assign unused_mode = mode;
`endif

  key_index_ctr #(
    .IDX_W (C_IDX_W),
    .N_W   (3)
  ) u_idx (
    .clk   (dclk),
    .rst_n (reset),
    .clr   (idx_clr),
    .adv   (accept),
    .n     (n_snap_q),
    .idx   (idx)
  );

  // Handshake, key select and next-state logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    key_err_d   = key_err_q;
    byte_cnt_d  = byte_cnt_q;
    key_snap_d  = key_snap_q;
    n_snap_d    = n_snap_q;
    idx_clr     = 1'b0;

    // kset gating keeps the kset-low cycle from ever accepting a byte
    in_ready = (state_q == ST_RUN) && kset && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    key_byte = key_snap_q[idx*KEY_BYTE_W +: KEY_BYTE_W];
`ifdef KEY_XOR_CHAIN_EN
    chain_d  = chain_q;
    xor_val  = in_data ^ key_byte ^ chain_q;
`else
    xor_val  = in_data ^ key_byte;
`endif

    case (state_q)
      ST_IDLE: begin
        if (kset) begin
          if (num_keys_ok(num_keys)) begin
            state_d    = ST_RUN;
            key_snap_d = keys;
            n_snap_d   = num_keys;
            byte_cnt_d = '0;
            idx_clr    = 1'b1;
`ifdef KEY_XOR_CHAIN_EN
            chain_d    = '0;
`endif
          end else begin
            state_d   = ST_ERR;
            key_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!kset) begin
          if (out_valid_q && !out_ready) begin
            state_d = ST_DRAIN;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end else if (accept) begin
          out_data_d  = xor_val;
          out_valid_d = 1'b1;
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
`ifdef KEY_XOR_CHAIN_EN
          // The chain always carries the ciphertext side of the stream
          chain_d     = mode ? in_data : xor_val;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (!kset) begin
          key_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      key_err_q   <= 1'b0;
      byte_cnt_q  <= '0;
      key_snap_q  <= '0;
      n_snap_q    <= '0;
`ifdef KEY_XOR_CHAIN_EN
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      key_err_q   <= key_err_d;
      byte_cnt_q  <= byte_cnt_d;
      key_snap_q  <= key_snap_d;
      n_snap_q    <= n_snap_d;
`ifdef KEY_XOR_CHAIN_EN
      chain_q     <= chain_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign key_err   = key_err_q;
  assign byte_cnt  = byte_cnt_q;

endmodule
`default_nettype wire
